sample_feeder: RTL

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder.sv | 116 +++++++++++
 1 files changed

// File: rtl/sample_feeder.sv
// sample_feeder: buffers one parallel sample word from the ADC/MSP430 side and
// serializes it MSB first to the read responder, one bit per readbitclk edge,
// while read_sample_ctl is held high.
//
// Ports:
//   reset              in   asynchronous, active-high reset
//   readbitclk         in   bit clock, all state updates on the rising edge
//   read_sample_ctl    in   sample-window request (high while bits are wanted)
//   read_sample_datain out  serial sample bit, MSB first (0 outside SHIFT)
//   sample_data[15:0]  in   parallel sample word
//   sample_valid       in   producer offers sample_data this cycle
//   sample_ready       out  holding buffer can accept a word
//   busy               out  high while shifting
//   underrun           out  sticky: a load found no sample available
//   words_sent[7:0]    out  number of loads into the shifter (wraps)
module sample_feeder #(
  parameter logic [15:0] UNDERRUN_WORD = 16'hFFFF
) (
  input  logic        reset,
  input  logic        readbitclk,
  input  logic        read_sample_ctl,
  output logic        read_sample_datain,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        underrun,
  output logic [7:0]  words_sent
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      r_state;
  logic [15:0] r_sreg;
  logic [3:0]  r_count;
  logic [15:0] r_buf;
  logic        r_full;
  logic        r_underrun;
  logic [7:0]  r_words;

  logic w_load;
  logic w_pass;
  logic w_buf_wr;

  // A load with an empty buffer takes a concurrently offered word straight
  // into the shifter; that word must not also land in the buffer.
  assign w_load   = (r_state == StIdle) && read_sample_ctl;
  assign w_pass   = w_load && !r_full && sample_valid;
  assign w_buf_wr = sample_valid && !r_full && !w_pass;

  always_ff @(posedge readbitclk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_sreg     <= 16'h0000;
      r_count    <= 4'd0;
      r_buf      <= 16'h0000;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
      r_words    <= 8'd0;
    end else begin
      // Write and buffer-load never collide: write needs !full, load needs full.
      if (w_buf_wr) begin
        r_buf  <= sample_data;
        r_full <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (read_sample_ctl) begin
            r_count <= 4'd0;
            r_words <= r_words + 8'd1;
            r_state <= StShift;
            if (r_full) begin
              r_sreg <= r_buf;
              r_full <= 1'b0;
            end else if (sample_valid) begin
              r_sreg <= sample_data;
            end else begin
              r_sreg     <= UNDERRUN_WORD;
              r_underrun <= 1'b1;
            end
          end
        end

        StShift: begin
          if (read_sample_ctl) begin
            r_sreg  <= {r_sreg[14:0], 1'b0};
            r_count <= r_count + 4'd1;
            // Bit 0 has been on the line for a full cycle once count hits 15.
            if (r_count == 4'd15) begin
              r_state <= StDone;
            end
          end else begin
            // Window closed early: the partial word is dropped.
            r_state <= StIdle;
          end
        end

        StDone: begin
          if (!read_sample_ctl) begin
            r_state <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign read_sample_datain = (r_state == StShift) && r_sreg[15];
  assign sample_ready       = !r_full;
  assign busy               = (r_state == StShift);
  assign underrun           = r_underrun;
  assign words_sent         = r_words;

endmodule
